// File: rtl/spi_pkg.sv
// Shared definitions for the SPI secondary: FSM state encoding, default
// transfer width, default underrun fill word and synchronizer depth.
package spi_pkg;

  localparam int unsigned DWIDTH_DEFAULT = 8;
  localparam int unsigned FILL_DEFAULT   = 0;
  localparam int unsigned SYNC_STAGES    = 2;

  typedef enum logic [0:0] {
    SPI_IDLE = 1'b0,
    SPI_XFER = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_secondary_if.sv
// Local-side handshake bundle of the SPI secondary.
//   tx_data/tx_valid/tx_ready : word offered for transmission (valid/ready)
//   rx_data/rx_valid          : last received word plus one-cycle valid pulse
// master: local logic using the port; slave: the SPI secondary itself.
interface spi_secondary_if
  import spi_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEFAULT
);

  logic [DWIDTH-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DWIDTH-1:0] rx_data;
  logic              rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );

endinterface

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer for asynchronous SPI pins.
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output (SYNC_STAGES flops deep)
// RST_VAL lets an idle-high pin such as cs_n come out of reset inactive.
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= {SYNC_STAGES{RST_VAL}};
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_secondary.sv
// SPI secondary, mode 0 (CPOL=0, CPHA=0), MSB first, fully oversampled in
// the clk domain (clk must be at least 4x sclk).
//   clk, rst_n       : system clock, asynchronous active-low reset
//   sclk, cs_n, mosi : asynchronous pins from the initiator
//   miso             : registered data to the initiator (0 while idle)
//   bus (slave)      : tx holding register handshake, rx word + valid pulse
//   err              : only with SPI_SEC_ERR_EN defined; one-cycle pulse on
//                      transmit underrun or on mid-word chip-select abort
module spi_secondary
  import spi_pkg::*;
#(
  parameter int unsigned       DWIDTH = DWIDTH_DEFAULT,
  parameter logic [DWIDTH-1:0] FILL   = DWIDTH'(FILL_DEFAULT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
`ifdef SPI_SEC_ERR_EN
  output logic err,
`endif
  spi_secondary_if.slave bus
);

  localparam int unsigned CNT_W = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam int unsigned RX_W  = DWIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DWIDTH - 1);

  // Pin synchronizers and edge-detect registers
  logic sclk_s, cs_s, mosi_s;
  logic sclk_d, cs_d;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  logic sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;
  assign sclk_rise_c = sclk_s & ~sclk_d;
  assign sclk_fall_c = ~sclk_s & sclk_d;
  assign cs_fall_c   = ~cs_s & cs_d;
  assign cs_rise_c   = cs_s & ~cs_d;

  // Datapath state
  spi_state_e        state, state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              reload_pend;   // word complete, next sclk fall loads
  logic [DWIDTH-1:0] tx_sh;
  logic [RX_W-1:0]   rx_sh;
  logic [DWIDTH-1:0] hold_data;
  logic              hold_empty;
  logic [DWIDTH-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              miso_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SPI_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: chip select alone moves between idle and transfer
  always_comb begin
    state_next = state;
    case (state)
      SPI_IDLE: if (cs_fall_c) state_next = SPI_XFER;
      SPI_XFER: if (cs_rise_c) state_next = SPI_IDLE;
      default:  state_next = SPI_IDLE;
    endcase
  end

  // FSM action decode; a chip-select rise overrides any coincident sclk edge
  logic load_c, shift_c, rise_c, drop_c;
  always_comb begin
    load_c  = 1'b0;
    shift_c = 1'b0;
    rise_c  = 1'b0;
    drop_c  = 1'b0;
    case (state)
      SPI_IDLE: load_c = cs_fall_c;
      SPI_XFER: begin
        if (cs_rise_c) begin
          drop_c = 1'b1;
        end else begin
          rise_c = sclk_rise_c;
          if (sclk_fall_c) begin
            if (reload_pend) load_c  = 1'b1;
            else             shift_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Accept only into an empty register; a same-cycle load still sees it empty
  logic accept_c;
  assign accept_c = bus.tx_valid & hold_empty;

  // Transmit holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_empty <= 1'b1;
    end else begin
      if (load_c && !hold_empty) hold_empty <= 1'b1;
      if (accept_c) begin
        hold_data  <= bus.tx_data;
        hold_empty <= 1'b0;
      end
    end
  end

  // Transmit shifter and miso, which trails the shifter MSB by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh  <= '0;
      miso_q <= 1'b0;
    end else begin
      if (load_c) begin
        tx_sh <= hold_empty ? FILL : hold_data;
      end else if (shift_c) begin
        tx_sh <= {tx_sh[DWIDTH-2:0], 1'b0};
      end else if (drop_c) begin
        tx_sh <= '0;
      end
      miso_q <= (state == SPI_XFER) ? tx_sh[DWIDTH-1] : 1'b0;
    end
  end

  // Receive shifter, bit counter and completed-word output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh       <= '0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (drop_c) begin
        rx_sh       <= '0;
        bit_cnt     <= '0;
        reload_pend <= 1'b0;
      end else if (rise_c) begin
        rx_sh <= RX_W'({rx_sh, mosi_s});
        if (bit_cnt == LAST_BIT) begin
          rx_data_q   <= {rx_sh, mosi_s};
          rx_valid_q  <= 1'b1;
          bit_cnt     <= '0;
          reload_pend <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (load_c) begin
        reload_pend <= 1'b0;
      end
    end
  end

`ifdef SPI_SEC_ERR_EN
  // Underrun and abort OR together so a coincidence gives a single pulse
  logic underrun_c, abort_c, err_q;
  assign underrun_c = load_c & hold_empty;
  assign abort_c    = drop_c & (bit_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= underrun_c | abort_c;
    end
  end

  assign err = err_q;
`endif

  assign miso         = miso_q;
  assign bus.tx_ready = hold_empty;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
